// File: rtl/fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_wr_arbiter
//  Description : Round-robin arbiter sharing one fifo write port between
//                NUM_REQ producers. Grants bounded bursts of up to MAX_BURST
//                beats, stalls on fifo_full, muxes the granted data onto the
//                fifo write side.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_wr_arbiter #(
    parameter  int NUM_REQ    = 4,
    parameter  int DATA_WIDTH = 8,
    parameter  int MAX_BURST  = 4,
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          wr_en,
    output logic [DATA_WIDTH-1:0]         data_wr,
    output logic [ID_WIDTH-1:0]           grant_id,
    output logic                          busy
);

    localparam int                      c_CNT_WIDTH = $clog2(MAX_BURST + 1);
    localparam logic [c_CNT_WIDTH-1:0]  c_LAST_BEAT = c_CNT_WIDTH'(MAX_BURST - 1);
    // Pointer starts on the last requester so requester 0 wins first
    localparam logic [ID_WIDTH-1:0]     c_PTR_RST   = ID_WIDTH'(NUM_REQ - 1);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_next;
    logic [ID_WIDTH-1:0]     r_grant_id;
    logic [ID_WIDTH-1:0]     w_grant_next;
    logic [ID_WIDTH-1:0]     r_last_ptr;
    logic [ID_WIDTH-1:0]     w_last_next;
    logic [c_CNT_WIDTH-1:0]  r_beat_cnt;
    logic [c_CNT_WIDTH-1:0]  w_beat_next;
    logic [ID_WIDTH-1:0]     w_scan_base;
    logic [ID_WIDTH-1:0]     w_scan_idx;
    logic [ID_WIDTH-1:0]     w_winner;
    logic                    w_any_valid;
    logic                    w_beat;
    logic                    w_release;
    logic [DATA_WIDTH-1:0]   w_slice [NUM_REQ];

    // Unpack the flat data bus into one word per requester
    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_slice
            assign w_slice[k] = req_data[k*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    // While granted, the scan starts after the current owner so that a
    // release re-arbitrates with the owner ranked last; in IDLE it starts
    // after the last released owner.
    assign w_scan_base = (r_state == ST_GRANT) ? r_grant_id : r_last_ptr;
    assign grant_id    = r_grant_id;

    // Round-robin search: first valid requester after the scan base, wrapping
    always_comb begin
        w_winner    = '0;
        w_any_valid = 1'b0;
        w_scan_idx  = '0;
        for (int i = 1; i <= NUM_REQ; i++) begin
            w_scan_idx = ID_WIDTH'((int'(w_scan_base) + i) % NUM_REQ);
            if (!w_any_valid && req_valid[w_scan_idx]) begin
                w_winner    = w_scan_idx;
                w_any_valid = 1'b1;
            end
        end
    end

    // Next-state, burst accounting and write-port mux
    always_comb begin
        w_state_next = r_state;
        w_grant_next = r_grant_id;
        w_last_next  = r_last_ptr;
        w_beat_next  = r_beat_cnt;
        req_ready    = '0;
        wr_en        = 1'b0;
        data_wr      = '0;
        busy         = 1'b0;
        w_beat       = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_any_valid) begin
                    w_grant_next = w_winner;
                    w_beat_next  = '0;
                    w_state_next = ST_GRANT;
                end
            end
            ST_GRANT: begin
                busy                  = 1'b1;
                req_ready[r_grant_id] = !fifo_full;
                w_beat                = req_valid[r_grant_id] & !fifo_full;
                wr_en                 = w_beat;
                data_wr               = w_slice[r_grant_id];
                // A full fifo never ends a grant: no beat, counter frozen
                w_release = (w_beat && (r_beat_cnt == c_LAST_BEAT)) ||
                            !req_valid[r_grant_id];
                if (w_release) begin
                    w_last_next = r_grant_id;
                    w_beat_next = '0;
                    if (w_any_valid) begin
                        w_grant_next = w_winner;
                    end else begin
                        w_state_next = ST_IDLE;
                    end
                end else if (w_beat) begin
                    w_beat_next = r_beat_cnt + 1'b1;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // State and arbitration registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_grant_id <= '0;
            r_last_ptr <= c_PTR_RST;
            r_beat_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_grant_id <= w_grant_next;
            r_last_ptr <= w_last_next;
            r_beat_cnt <= w_beat_next;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_wr_arbiter
//  Description : Self-checking bench for fifo_wr_arbiter. Random producers
//                obeying the valid/ready rules, random fifo_full, compared
//                each cycle against a burst-level round-robin reference and
//                a per-requester ordering scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_wr_arbiter;

    localparam int NUM_REQ    = 4;
    localparam int DATA_WIDTH = 8;
    localparam int MAX_BURST  = 4;
    localparam int ID_WIDTH   = $clog2(NUM_REQ);

    logic                          clk = 1'b0;
    logic                          rst_n;
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ*DATA_WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          fifo_full;
    logic                          wr_en;
    logic [DATA_WIDTH-1:0]         data_wr;
    logic [ID_WIDTH-1:0]           grant_id;
    logic                          busy;

    fifo_wr_arbiter #(
        .NUM_REQ    (NUM_REQ),
        .DATA_WIDTH (DATA_WIDTH),
        .MAX_BURST  (MAX_BURST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .fifo_full (fifo_full),
        .wr_en     (wr_en),
        .data_wr   (data_wr),
        .grant_id  (grant_id),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int                    n_checks = 0;
    int                    n_fail   = 0;
    logic [7:0]            src_q [NUM_REQ][$];
    logic [7:0]            fifo_log [$];
    logic [NUM_REQ-1:0]    done_beat;
    int                    p_valid [NUM_REQ];
    int                    p_full;
    int                    seq [NUM_REQ];
    // Reference: owner (-1 = idle), beats taken this grant, last releaser
    int                    m_owner;
    int                    m_beats;
    int                    m_last;
    int                    m_gid;

    task automatic check_value(input string tag, input logic [31:0] got,
                               input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int pick(input int start, input logic [NUM_REQ-1:0] v);
        for (int i = 1; i <= NUM_REQ; i++) begin
            if (v[(start + i) % NUM_REQ]) return (start + i) % NUM_REQ;
        end
        return -1;
    endfunction

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < NUM_REQ; k++) s += src_q[k].size();
        return s;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_beats = 0;
        m_last  = NUM_REQ - 1;
        m_gid   = 0;
    endtask

    task automatic fill(input int k, input int n);
        for (int i = 0; i < n; i++) begin
            src_q[k].push_back(8'(k * 64 + (seq[k] % 64)));
            seq[k]++;
        end
    endtask

    task automatic set_all_p(input int p);
        for (int k = 0; k < NUM_REQ; k++) p_valid[k] = p;
    endtask

    // Producers: hold valid/data until accepted, then optionally go quiet
    task automatic drive_inputs();
        for (int k = 0; k < NUM_REQ; k++) begin
            if (done_beat[k]) req_valid[k] = 1'b0;
            if (!req_valid[k] && src_q[k].size() > 0 &&
                int'($urandom_range(0, 99)) < p_valid[k])
                req_valid[k] = 1'b1;
            req_data[k*DATA_WIDTH +: DATA_WIDTH] =
                req_valid[k] ? src_q[k][0] : 8'($urandom);
        end
        done_beat = '0;
        fifo_full = (int'($urandom_range(0, 99)) < p_full);
    endtask

    task automatic cycle_body();
        logic [NUM_REQ-1:0] v;
        logic [NUM_REQ-1:0] e_ready;
        logic               e_wr;
        logic [7:0]         e_data;
        logic [7:0]         head;
        int                 w;
        drive_inputs();
        #1;
        v       = req_valid;
        e_ready = '0;
        e_wr    = 1'b0;
        e_data  = '0;
        if (m_owner >= 0) begin
            e_wr = v[m_owner] && !fifo_full;
            if (!fifo_full) e_ready[m_owner] = 1'b1;
            e_data = req_data[m_owner*DATA_WIDTH +: DATA_WIDTH];
        end
        check_value("busy", 32'(busy), (m_owner >= 0) ? 32'd1 : 32'd0);
        check_value("wr_en", 32'(wr_en), 32'(e_wr));
        check_value("req_ready", 32'(req_ready), 32'(e_ready));
        check_value("grant_id", 32'(grant_id), (m_owner >= 0) ? 32'(m_owner) : 32'(m_gid));
        check_value("data_wr", 32'(data_wr), 32'(e_data));
        if (e_wr) begin
            head = src_q[m_owner].pop_front();
            check_value("fifo_order", 32'(data_wr), 32'(head));
            fifo_log.push_back(data_wr);
            done_beat[m_owner] = 1'b1;
        end
        if (m_owner < 0) begin
            w = pick(m_last, v);
            if (w >= 0) begin
                m_owner = w;
                m_gid   = w;
                m_beats = 0;
            end
        end else begin
            if (e_wr) m_beats++;
            if ((e_wr && m_beats == MAX_BURST) || !v[m_owner]) begin
                m_last = m_owner;
                w      = pick(m_owner, v);
                if (w >= 0) begin
                    m_owner = w;
                    m_gid   = w;
                    m_beats = 0;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        cycle_body();
    endtask

    task automatic drain(input int budget);
        int c = 0;
        while (pending() > 0 && c < budget) begin
            step();
            c++;
        end
        check_value("drain_timeout", 32'(pending()), 32'd0);
        repeat (3) step();
    endtask

    // Asynchronous reset in the middle of traffic
    task automatic reset_pulse();
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check_value("rst_async_wr_en", 32'(wr_en), 32'd0);
        check_value("rst_async_req_ready", 32'(req_ready), 32'd0);
        check_value("rst_async_busy", 32'(busy), 32'd0);
        check_value("rst_async_grant_id", 32'(grant_id), 32'd0);
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cycle_body();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_data  = '0;
        fifo_full = 1'b0;
        done_beat = '0;
        p_full    = 0;
        set_all_p(0);
        for (int k = 0; k < NUM_REQ; k++) seq[k] = 0;
        model_reset();

        // Reset state, then first grant goes to requester 0
        #12;
        check_value("rst_wr_en", 32'(wr_en), 32'd0);
        check_value("rst_req_ready", 32'(req_ready), 32'd0);
        check_value("rst_busy", 32'(busy), 32'd0);
        check_value("rst_grant_id", 32'(grant_id), 32'd0);
        check_value("rst_data_wr", 32'(data_wr), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        cycle_body();
        for (int k = 0; k < NUM_REQ; k++) fill(k, 8);
        set_all_p(100);
        step();
        check_value("first_ready_latency", 32'(req_ready), 32'd0);
        step();
        check_value("first_grant", 32'(grant_id), 32'd0);
        drain(200);

        // Single requester 2, ten beats 0x10..0x19, re-grant to itself
        fifo_log.delete();
        for (int i = 0; i < 10; i++) src_q[2].push_back(8'(8'h10 + i));
        set_all_p(0);
        p_valid[2] = 100;
        drain(100);
        check_value("solo_count", 32'(fifo_log.size()), 32'd10);
        for (int i = 0; i < 10 && i < fifo_log.size(); i++)
            check_value("solo_data", 32'(fifo_log[i]), 32'(8'h10 + i));

        // All requesters continuously valid: 4-beat rotating blocks
        for (int k = 0; k < NUM_REQ; k++) fill(k, 8);
        set_all_p(100);
        drain(200);

        // Random producers with random back-pressure
        p_full = 25;
        for (int k = 0; k < NUM_REQ; k++) begin
            p_valid[k] = int'($urandom_range(30, 100));
            fill(k, 24);
        end
        drain(3000);

        // Reset mid-burst, priority restarts at requester 0
        p_full = 0;
        set_all_p(100);
        for (int k = 0; k < NUM_REQ; k++) fill(k, 12);
        repeat (6) step();
        reset_pulse();
        step();
        check_value("post_rst_grant", 32'(grant_id), 32'd0);
        drain(400);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
